lc3_mem_access_ctrl: RTL
========================

Name: lc3_mem_access_ctrl

Overview:
- Sequences the LC3 data-memory access stage for one load/store instruction at a time.
- Accepts an op from decode/execute, drives mem_state and M_Control into the memory-access datapath, and stalls the pipeline until the access completes.
- Handles the two-phase indirect ops (LDI/STI): address fetch first, then the data access.
- Fixed wait-states per phase model slow data memory.

Parameters:
- WAIT_CYCLES, 0, extra cycles each memory phase is held (phase length = WAIT_CYCLES+1).
- CNT_W, 16, width of the optional performance counters.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  memory op presented by execute
- req_ready  out  1  controller can accept an op
- req_op  in  3  0=LD, 1=LDR, 2=LDI, 3=ST, 4=STR, 5=STI, 6/7 illegal
- mem_state  out  2  0=indirect-address read, 1=data read, 2=data write, 3=idle
- M_Control  out  1  1 = use indirect read data as the address (second phase of LDI/STI)
- stall  out  1  hold upstream pipeline
- wb_en  out  1  one-cycle pulse: memout valid for register writeback
- done  out  1  one-cycle pulse: op complete
- err  out  1  one-cycle pulse: illegal op consumed
- rd_count  out  CNT_W  reads issued (only with LC3_MEM_PERF_EN)
- wr_count  out  CNT_W  writes issued (only with LC3_MEM_PERF_EN)

Behaviour:
- Reset values: FSM=IDLE, mem_state=3, M_Control=0, stall=0, wb_en=0, done=0, err=0, counters=0, req_ready=1.
- States: IDLE, IND, RD, WR. mem_state is 3/0/1/2 respectively, registered from state.
- req_ready=1 only in IDLE. An op is accepted on a rising edge where req_valid && req_ready.
- On accept, next state is chosen by op:
  - LD/LDR -> RD
  - ST/STR -> WR
  - LDI/STI -> IND
  - 6/7 -> stay IDLE, err pulses the next cycle, no memory activity.
- Each phase lasts WAIT_CYCLES+1 cycles, timed by a down-counter loaded on phase entry.
- Phase transitions:
  - End of IND: go to RD (LDI) or WR (STI), with M_Control=1 for that phase.
  - End of RD: wb_en=1 and done=1 during the final cycle of the phase, then IDLE.
  - End of WR: done=1 during the final cycle, then IDLE.
- M_Control clears on return to IDLE. It is 0 for LD/LDR/ST/STR and for the IND phase.
- stall = (state != IDLE).
- Latency with WAIT_CYCLES=0, accept at edge E:
  - LD: RD in cycle E+1 with done/wb_en, IDLE at E+2.
  - LDI: IND at E+1, RD at E+2 with done, IDLE at E+3.
- Back-to-back ops: a new op may be accepted on the edge that returns the FSM to IDLE plus one. There is no overlap and at least one IDLE cycle between ops.
- req_op is sampled only at accept; changes while busy are ignored.
- Asynchronous reset mid-op aborts immediately to the reset values; no done or wb_en is issued for the aborted op.
- The wait counter never underflows. With WAIT_CYCLES=0 the counter is absent or constant.

Optional Feature:
- Macro: LC3_MEM_PERF_EN.
- Defined:
  - rd_count increments once per completed IND or RD phase; wr_count increments once per completed WR phase.
  - Both saturate at all-ones and clear on reset.
- Undefined: rd_count/wr_count ports are absent and no counter logic is built.

Decomposition:
- Package lc3_mem_ctrl_pkg holds:
  - op codes (LD..STI)
  - mem_state encodings (MS_IND=0, MS_RD=1, MS_WR=2, MS_IDLE=3)
  - the FSM state typedef.
- Sub-module lc3_mem_wait_cnt: loadable down-counter with a last-cycle flag, parameterised by WAIT_CYCLES.

Test Plan:
- Reset asserted mid-LDI IND phase (WAIT_CYCLES=2) -> next cycle mem_state=3, M_Control=0, stall=0; no done or wb_en pulse follows.
- WAIT_CYCLES=0, LD accepted at cycle 5 -> mem_state=1 at cycle 6 with wb_en=done=1; mem_state=3 and req_ready=1 at cycle 7.
- WAIT_CYCLES=2, STI -> mem_state=0 for 3 cycles (M_Control=0), then mem_state=2 for 3 cycles (M_Control=1); done on the 6th busy cycle; stall high for exactly 6 cycles.
- req_op=7 with req_valid -> err pulses once, mem_state stays 3, stall stays 0, done never asserts.
- LDR then STR presented back-to-back with req_valid held -> second op accepted only after the IDLE return; mem_state sequence is 3,1,3,2,3.
- LC3_MEM_PERF_EN defined, CNT_W=2, five LD ops -> rd_count=3 (saturated), wr_count=0.

Source files
------------

// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared encodings for the LC3 memory-access controller: op codes, mem_state
// values and the FSM state type, plus small decode helpers.
package lc3_mem_ctrl_pkg;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_LDR = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_STR = 3'd4;
  localparam logic [2:0] OP_STI = 3'd5;

  localparam logic [1:0] MS_IND  = 2'd0;
  localparam logic [1:0] MS_RD   = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IND  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } fsm_e;

  function automatic logic [1:0] ms_of_state(input fsm_e s);
    logic [1:0] ms;
    case (s)
      ST_IND:  ms = MS_IND;
      ST_RD:   ms = MS_RD;
      ST_WR:   ms = MS_WR;
      default: ms = MS_IDLE;
    endcase
    return ms;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_STI);
  endfunction

endpackage

// File: rtl/lc3_mem_wait_cnt.sv
// Phase timer: loadable down-counter that flags the last cycle of a memory
// phase (WAIT_CYCLES+1 cycles long). With WAIT_CYCLES=0 no counter is built.
module lc3_mem_wait_cnt #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic last,
  output logic last_nxt
);

  generate
    if (WAIT_CYCLES == 0) begin : g_no_cnt
      logic unused_s;
      assign unused_s = load ^ clock ^ reset;
      assign last     = 1'b1;
      assign last_nxt = 1'b1;
    end else begin : g_cnt
      localparam int CW = $clog2(WAIT_CYCLES + 1);
      localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);
      localparam logic [CW-1:0] ONE      = CW'(1);

      logic [CW-1:0] cnt_r;
      logic [CW-1:0] cnt_nxt_s;

      // Next count: reload on phase entry, otherwise count down and hold at zero
      always_comb begin
        if (load) begin
          cnt_nxt_s = LOAD_VAL;
        end else if (cnt_r != '0) begin
          cnt_nxt_s = cnt_r - ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      // Counter register
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_nxt_s;
        end
      end

      // last_nxt lets the parent register its end-of-phase pulses
      assign last     = (cnt_r == '0);
      assign last_nxt = (cnt_nxt_s == '0);
    end
  endgenerate

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// LC3 data-memory access sequencer: one load/store at a time, with two-phase
// LDI/STI and fixed wait-states. Optional counters under LC3_MEM_PERF_EN.
module lc3_mem_access_ctrl
  import lc3_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  output logic [1:0]       mem_state,
  output logic             M_Control,
  output logic             stall,
  output logic             wb_en,
  output logic             done,
  output logic             err
`ifdef LC3_MEM_PERF_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  fsm_e       state_r;
  fsm_e       next_s;
  logic       accept_s;
  logic       ind_store_r;
  logic       load_s;
  logic       last_s;
  logic       last_nxt_s;
  logic [1:0] ms_nxt_s;
  logic       mctrl_nxt_s;
  logic       stall_nxt_s;
  logic       ready_nxt_s;
  logic       done_nxt_s;
  logic       wb_nxt_s;
  logic       err_nxt_s;

  assign accept_s = req_valid && req_ready;
  assign load_s   = (next_s != ST_IDLE) && (next_s != state_r);

  lc3_mem_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .last     (last_s),
    .last_nxt (last_nxt_s)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Remember whether an indirect op is the store flavour for its second phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ind_store_r <= 1'b0;
    end else if (accept_s) begin
      ind_store_r <= (req_op == OP_STI);
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (req_op)
            OP_LD, OP_LDR:  next_s = ST_RD;
            OP_ST, OP_STR:  next_s = ST_WR;
            OP_LDI, OP_STI: next_s = ST_IND;
            default:        next_s = ST_IDLE;
          endcase
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_IND: begin
        if (last_s) begin
          next_s = ind_store_r ? ST_WR : ST_RD;
        end else begin
          next_s = ST_IND;
        end
      end
      ST_RD, ST_WR: begin
        if (last_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s = state_r;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so every output leaves a flop
  always_comb begin
    ms_nxt_s    = ms_of_state(next_s);
    stall_nxt_s = (next_s != ST_IDLE);
    ready_nxt_s = (next_s == ST_IDLE);
    done_nxt_s  = ((next_s == ST_RD) || (next_s == ST_WR)) && last_nxt_s;
    wb_nxt_s    = (next_s == ST_RD) && last_nxt_s;
    err_nxt_s   = accept_s && !op_is_legal(req_op);
    if ((state_r == ST_IND) && (next_s != ST_IND)) begin
      mctrl_nxt_s = 1'b1;
    end else if ((next_s == ST_RD) || (next_s == ST_WR)) begin
      mctrl_nxt_s = M_Control;
    end else begin
      mctrl_nxt_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_state <= MS_IDLE;
      M_Control <= 1'b0;
      stall     <= 1'b0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      wb_en     <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_state <= ms_nxt_s;
      M_Control <= mctrl_nxt_s;
      stall     <= stall_nxt_s;
      req_ready <= ready_nxt_s;
      done      <= done_nxt_s;
      wb_en     <= wb_nxt_s;
      err       <= err_nxt_s;
    end
  end

`ifdef LC3_MEM_PERF_EN
  logic rd_inc_s;
  logic wr_inc_s;

  assign rd_inc_s = ((state_r == ST_IND) || (state_r == ST_RD)) && last_s;
  assign wr_inc_s = (state_r == ST_WR) && last_s;

  // Saturating phase counters, bumped on the edge that completes a phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_inc_s && (rd_count != '1)) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (wr_inc_s && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
